// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: one opcode at a time through DECODE/EXEC/MEM/WB, with MUL stall, memory timeout and illegal-op trap.
// Latency: ADD writeback 3 cycles after accept; backpressure: instr_ready only in IDLE, memory access held until mem_ready.
module multicycle_control #(
    parameter int OP_W        = 6,
    parameter int ALU_CTRL_W  = 4,
    parameter int MUL_LAT     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [OP_W-1:0]       op,
    input  logic                  zero,
    input  logic                  mem_ready,
    input  logic                  trap_clr,
    output logic                  reg_dest,
    output logic                  alu_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_byte,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  branch,
    output logic                  jump,
    output logic                  pc_write,
    output logic                  tlb_write,
    output logic                  iret,
    output logic                  illegal_op,
    output logic                  mem_timeout,
    output logic                  busy
);
    localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [MC_W-1:0] MUL_INIT = MC_W'(MUL_LAT - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3,  OP_OR   = 5'd4,  OP_ADDI = 5'd5;
    localparam logic [4:0] OP_LBD  = 5'd10, OP_LDW  = 5'd11, OP_STB  = 5'd12;
    localparam logic [4:0] OP_STW  = 5'd13, OP_MOV  = 5'd14, OP_BEQ  = 5'd20;
    localparam logic [4:0] OP_JUMP = 5'd21, OP_TLBW = 5'd30, OP_IRET = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t          state_q;
    logic [OP_W-1:0] op_q;
    logic [MC_W-1:0] mul_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            illegal_q;
    logic            tmo_q;

    logic [4:0] lo;
    logic       hi_zero;
    logic       is_rtype, is_mul, is_addi, is_load, is_store, is_mem, is_byte;
    logic       is_beq, is_jump, is_tlbw, is_iret, is_legal;
    logic [2:0] alu_code;

    // Classification of the latched opcode; any set bit above bit 4 makes it illegal.
    always_comb begin
        lo       = op_q[4:0];
        hi_zero  = ((op_q >> 5) == '0);
        is_rtype = hi_zero && (lo inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR});
        is_mul   = hi_zero && (lo == OP_MUL);
        is_addi  = hi_zero && (lo == OP_ADDI);
        is_load  = hi_zero && (lo inside {OP_LBD, OP_LDW});
        is_store = hi_zero && (lo inside {OP_STB, OP_STW, OP_MOV});
        is_mem   = is_load || is_store;
        is_byte  = hi_zero && (lo inside {OP_LBD, OP_STB});
        is_beq   = hi_zero && (lo == OP_BEQ);
        is_jump  = hi_zero && (lo == OP_JUMP);
        is_tlbw  = hi_zero && (lo == OP_TLBW);
        is_iret  = hi_zero && (lo == OP_IRET);
        is_legal = is_rtype || is_addi || is_mem || is_beq || is_jump || is_tlbw || is_iret;
        case (lo)
            OP_SUB, OP_BEQ: alu_code = 3'd1;
            OP_MUL:         alu_code = 3'd2;
            OP_AND:         alu_code = 3'd3;
            OP_OR:          alu_code = 3'd4;
            default:        alu_code = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            mul_cnt_q <= '0;
            to_cnt_q  <= '0;
            illegal_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q    <= op;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!is_legal) begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q   <= S_EXEC;
                        mul_cnt_q <= MUL_INIT;
                    end
                end
                S_EXEC: begin
                    if (is_mul) begin
                        if (mul_cnt_q == '0) state_q <= S_WB;
                        else                 mul_cnt_q <= mul_cnt_q - 1'b1;
                    end else if (is_rtype || is_addi) begin
                        state_q <= S_WB;
                    end else if (is_mem) begin
                        state_q  <= S_MEM;
                        to_cnt_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MEM: begin
                    // A completion on the last allowed cycle takes priority over the timeout.
                    if (mem_ready) begin
                        state_q <= is_load ? S_WB : S_IDLE;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= S_TRAP;
                        tmo_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_WB: state_q <= S_IDLE;
                S_TRAP: begin
                    if (trap_clr) begin
                        state_q   <= S_IDLE;
                        illegal_q <= 1'b0;
                        tmo_q     <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        illegal_op  = illegal_q;
        mem_timeout = tmo_q;
        reg_dest    = 1'b0;
        alu_src     = 1'b0;
        alu_ctrl    = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_byte    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        pc_write    = 1'b0;
        tlb_write   = 1'b0;
        iret        = 1'b0;
        case (state_q)
            S_EXEC: begin
                alu_ctrl  = ALU_CTRL_W'(alu_code);
                alu_src   = is_addi || is_mem;
                branch    = is_beq;
                jump      = is_jump;
                tlb_write = is_tlbw;
                iret      = is_iret;
                pc_write  = (is_beq && zero) || is_jump || is_iret;
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
                mem_byte  = is_byte;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dest   = is_rtype;
                mem_to_reg = is_load;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cases then randomized transactions against a cycle-count model.
module tb_multicycle_control;
    localparam int MUL_LAT     = 3;
    localparam int MEM_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [5:0] op = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       trap_clr = 1'b0;
    logic       instr_ready, reg_dest, alu_src, mem_read, mem_write, mem_byte, mem_to_reg;
    logic       reg_write, branch, jump, pc_write, tlb_write, iret, illegal_op, mem_timeout, busy;
    logic [3:0] alu_ctrl;

    typedef struct packed {
        logic       instr_ready;
        logic       busy;
        logic       reg_dest;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       pc_write;
        logic       tlb_write;
        logic       iret;
        logic       illegal_op;
        logic       mem_timeout;
    } obs_t;

    obs_t got;
    assign got = {instr_ready, busy, reg_dest, alu_src, alu_ctrl, mem_read, mem_write, mem_byte,
                  mem_to_reg, reg_write, branch, jump, pc_write, tlb_write, iret, illegal_op, mem_timeout};

    int n_cmp = 0;
    int n_bad = 0;
    int legal_ops [15] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 13, 14, 20, 21, 30, 31};

    multicycle_control #(
        .OP_W(6), .ALU_CTRL_W(4), .MUL_LAT(MUL_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .zero(zero), .mem_ready(mem_ready), .trap_clr(trap_clr),
        .reg_dest(reg_dest), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte(mem_byte), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .branch(branch), .jump(jump), .pc_write(pc_write), .tlb_write(tlb_write), .iret(iret),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int t, input obs_t exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
        end
    endtask

    function automatic logic [3:0] alu_of(input int o);
        case (o)
            1, 20:   return 4'd1;
            2:       return 4'd2;
            3:       return 4'd3;
            4:       return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    // One instruction from its accept cycle (t=0) until the block is idle again.
    // d = MEM cycle index (0-based) on which mem_ready is raised; ntrap = TRAP cycles before trap_clr.
    task automatic run_txn(input string tag, input int o, input bit z, input int d,
                           input int ntrap, input int gap);
        bit   rt, ad, ld, st, mm, byt, beq, jmp, tlb, irt, legal, tmo, wb;
        int   ex_n, mem_n, tm0, twb, ttrap, tend;
        obs_t e;
        rt    = (o <= 4);
        ad    = (o == 5);
        ld    = (o == 10 || o == 11);
        st    = (o >= 12 && o <= 14);
        mm    = ld || st;
        byt   = (o == 10 || o == 12);
        beq   = (o == 20);
        jmp   = (o == 21);
        tlb   = (o == 30);
        irt   = (o == 31);
        legal = rt || ad || mm || beq || jmp || tlb || irt;
        ex_n  = (o == 2) ? MUL_LAT : 1;
        tmo   = mm && (d >= MEM_TIMEOUT);
        mem_n = mm ? (tmo ? MEM_TIMEOUT : d + 1) : 0;
        wb    = rt || ad || (ld && !tmo);
        tm0   = 2 + ex_n;
        twb   = tm0 + mem_n;
        if (!legal) begin
            ttrap = 2;
            tend  = 2 + ntrap + 1;
        end else if (tmo) begin
            ttrap = tm0 + mem_n;
            tend  = ttrap + ntrap + 1;
        end else begin
            tend  = twb + (wb ? 1 : 0);
            ttrap = tend + 1;
        end

        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            op          = 6'($urandom);
            zero        = 1'($urandom);
            mem_ready   = 1'($urandom);
            trap_clr    = 1'($urandom);
            #1;
            e = '0;
            e.instr_ready = 1'b1;
            check({tag, "/idle"}, g, e);
        end

        for (int t = 0; t < tend; t++) begin
            @(negedge clk);
            instr_valid = (t == 0 || !legal) ? 1'b1 : 1'($urandom);
            op          = (t == 0) ? 6'(o) : 6'($urandom);
            zero        = (t == 2) ? z : 1'($urandom);
            mem_ready   = (mm && t >= tm0 && t < tm0 + mem_n) ? (t - tm0 == d) : 1'($urandom);
            trap_clr    = (t >= ttrap) ? (t == tend - 1) : 1'($urandom);
            #1;
            e = '0;
            if (t == 0) e.instr_ready = 1'b1;
            else        e.busy = 1'b1;
            if (t >= ttrap) begin
                e.illegal_op  = !legal;
                e.mem_timeout = tmo;
            end else if (legal && t >= 2 && t < 2 + ex_n) begin
                e.alu_ctrl  = alu_of(o);
                e.alu_src   = ad || mm;
                e.branch    = beq;
                e.jump      = jmp;
                e.tlb_write = tlb;
                e.iret      = irt;
                e.pc_write  = (beq && z) || jmp || irt;
            end else if (mm && t >= tm0 && t < tm0 + mem_n) begin
                e.alu_src   = 1'b1;
                e.mem_read  = ld;
                e.mem_write = st;
                e.mem_byte  = byt;
            end else if (wb && t == twb) begin
                e.reg_write  = 1'b1;
                e.reg_dest   = rt;
                e.mem_to_reg = ld;
            end
            check(tag, t, e);
        end
    endtask

    initial begin
        obs_t e;
        repeat (2) @(negedge clk);
        #1;
        e = '0;
        e.instr_ready = 1'b1;
        check("reset", 0, e);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("add",      0,  1'b0, 0,   0, 0);
        run_txn("mul",      2,  1'b0, 0,   0, 1);
        run_txn("addi",     5,  1'b1, 0,   0, 0);
        run_txn("ldw_d4",   11, 1'b0, 4,   0, 1);
        run_txn("stb_d0",   12, 1'b0, 0,   0, 0);
        run_txn("stw_tmo",  13, 1'b0, 100, 3, 0);
        run_txn("stw_d15",  13, 1'b0, 15,  0, 0);
        run_txn("beq_z1",   20, 1'b1, 0,   0, 0);
        run_txn("beq_z0",   20, 1'b0, 0,   0, 0);
        run_txn("jump",     21, 1'b0, 0,   0, 0);
        run_txn("tlbw",     30, 1'b0, 0,   0, 0);
        run_txn("iret",     31, 1'b0, 0,   0, 0);
        run_txn("ill7",     7,  1'b0, 0,   2, 0);
        run_txn("ill63",    63, 1'b0, 0,   0, 0);
        run_txn("post_ill", 0,  1'b0, 0,   0, 0);

        // Asynchronous reset while a MUL is in its first EXEC cycle.
        @(negedge clk);
        instr_valid = 1'b1;
        op          = 6'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        e = '0;
        e.busy     = 1'b1;
        e.alu_ctrl = 4'd2;
        check("mul_pre_rst", 2, e);
        #2 rst_n = 1'b0;
        #1;
        e = '0;
        e.instr_ready = 1'b1;
        check("rst_async", 0, e);
        @(negedge clk);
        #1;
        check("rst_hold", 0, e);
        rst_n = 1'b1;
        run_txn("add_after_rst", 0, 1'b0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int o;
            int d;
            if ($urandom_range(0, 3) == 0) o = int'($urandom_range(0, 63));
            else                           o = legal_ops[$urandom_range(0, 14)];
            if ($urandom_range(0, 4) == 0) d = int'($urandom_range(13, 20));
            else                           d = int'($urandom_range(0, 4));
            run_txn("rand", o, 1'($urandom), d, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Accepts one opcode per instruction over a valid/ready handshake and sequences it through DECODE, EXEC, MEM and WB states. Each control strobe is asserted only in the state where it applies.
- Adds multi-cycle MUL, memory wait with timeout, branch/jump/TLB/IRET strobes and an illegal-opcode trap.
- Sits between the fetch stage and the datapath (ALU, register file, data memory, PC).

Parameters:
OP_W, 6, opcode width (>=5).
ALU_CTRL_W, 4, alu_ctrl width (>=3).
MUL_LAT, 3, EXEC cycles for MUL (>=1).
MEM_TIMEOUT, 16, max MEM cycles without mem_ready before trap (>=1).

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_valid  in  1  fetch presents an opcode.
instr_ready  out  1  block accepts an opcode (high only in IDLE).
op  in  OP_W  opcode, sampled on instr_valid & instr_ready.
zero  in  1  ALU zero flag, sampled in EXEC for BEQ.
mem_ready  in  1  data memory completes the current access.
trap_clr  in  1  leaves TRAP and clears trap flags.
reg_dest  out  1  1 = rd destination (R-type), 0 = rt.
alu_src  out  1  1 = immediate operand.
alu_ctrl  out  ALU_CTRL_W  ALU operation code.
mem_read  out  1  load request, held until mem_ready.
mem_write  out  1  store request, held until mem_ready.
mem_byte  out  1  byte access (LBD/STB).
mem_to_reg  out  1  writeback from memory.
reg_write  out  1  register file write strobe.
branch  out  1  BEQ evaluated this cycle.
jump  out  1  JUMP strobe.
pc_write  out  1  PC load strobe.
tlb_write  out  1  TLBWRITE strobe.
iret  out  1  IRET strobe.
illegal_op  out  1  sticky: undefined opcode.
mem_timeout  out  1  sticky: memory timeout.
busy  out  1  state != IDLE.

Behaviour:
- Opcode map, fixed:
  - ADD=0, SUB=1, MUL=2, AND=3, OR=4, ADDI=5
  - LBD=10, LDW=11, STB=12, STW=13, MOV=14
  - BEQ=20, JUMP=21, TLBWRITE=30, IRET=31
  - All other values are illegal. Bits of op above bit 4 must be 0 for a legal opcode.
- alu_ctrl encoding:
  - ADD, ADDI, loads, stores, MOV = 0
  - SUB = 1, BEQ = 1, MUL = 2, AND = 3, OR = 4
  - Zero-extended to ALU_CTRL_W.
- Reset (rst_n low, asynchronous, any state incl. mid-MEM/MUL):
  - State = IDLE; op_q, MUL counter, timeout counter = 0.
  - Every output = 0 except instr_ready = 1.
- States: IDLE, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: instr_ready = 1. On instr_valid: latch op into op_q, go to DECODE.
- DECODE (1 cycle): illegal op_q -> TRAP with illegal_op set. Otherwise -> EXEC; load MUL counter with MUL_LAT-1.
- EXEC: alu_ctrl and alu_src driven from op_q; alu_src = 1 for ADDI and memory ops.
  - MUL stays in EXEC until the counter reaches 0 (MUL_LAT EXEC cycles total).
  - R-type/ADDI -> WB.
  - LBD/LDW/STB/STW/MOV -> MEM; timeout counter cleared.
  - BEQ: branch = 1, pc_write = zero (same cycle) -> IDLE.
  - JUMP: jump = 1, pc_write = 1 -> IDLE.
  - TLBWRITE: tlb_write = 1 -> IDLE.
  - IRET: iret = 1, pc_write = 1 -> IDLE.
- MEM: alu_src = 1. mem_read (loads) or mem_write (STB/STW/MOV) held high every MEM cycle. mem_byte = 1 for LBD/STB.
  - mem_ready high: loads -> WB, stores -> IDLE.
  - Otherwise the counter increments. If mem_ready is still absent on the MEM_TIMEOUT-th MEM cycle -> TRAP with mem_timeout set.
  - mem_ready on that final cycle wins over the timeout.
- WB (1 cycle): reg_write = 1. reg_dest = 1 for ADD/SUB/MUL/AND/OR, else 0. mem_to_reg = 1 for loads -> IDLE.
- TRAP: busy = 1, all strobes 0, flags held. trap_clr -> IDLE with both flags cleared.
- Ignored inputs:
  - trap_clr outside TRAP.
  - mem_ready outside MEM.
  - instr_valid outside IDLE (instr_ready = 0).
- Latency, counted from the accept cycle c0:
  - ADD: reg_write at c3, instr_ready again at c4.
  - MUL (MUL_LAT=3): reg_write at c5.
  - LDW with mem_ready on first MEM cycle: MEM at c3, reg_write at c4.
- All outputs except pc_write during BEQ are functions of state and op_q only.

Test Plan:
- Reset: rst_n=0 mid-MUL EXEC -> next sampled values busy=0, instr_ready=1, all strobes 0; ADD accepted right after reset -> reg_write=1, reg_dest=1, alu_ctrl=0 at c3.
- MUL_LAT=3, op=2 -> EXEC for exactly 3 cycles with alu_ctrl=2, reg_write at c5; op=5 (ADDI) -> reg_write=1, reg_dest=0, alu_src=1 at c3.
- LDW with mem_ready delayed 4 MEM cycles -> mem_read high 5 cycles, then WB with mem_to_reg=1; STB with immediate mem_ready -> mem_write=1, mem_byte=1 for 1 cycle, back to IDLE, no reg_write.
- STW with mem_ready never asserted, MEM_TIMEOUT=16 -> 16 MEM cycles, then TRAP, mem_timeout=1; mem_ready on cycle 16 instead -> no trap.
- BEQ with zero=1 -> branch=1, pc_write=1 at c2; BEQ with zero=0 -> branch=1, pc_write=0; JUMP -> jump=1, pc_write=1; op=30 -> tlb_write=1; op=31 -> iret=1, pc_write=1.
- op=7 and op=63 -> TRAP at c2, illegal_op=1; instr_valid held high is ignored; trap_clr -> IDLE, illegal_op=0, next opcode accepted.
